// File: rtl/iperm_pkg.sv
// Shared types and constants for the iperm kp token scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the kp code width, butterfly stage count, beat counter width,
// the scheduler state enum, the command struct and the stage legality check.
package iperm_pkg;

  localparam int SELIN      = 3;   // kp code width; 2**SELIN > LOG2SLICES
  localparam int LOG2SLICES = 4;   // number of butterfly stages
  localparam int CNT_W      = 16;  // beats-per-stage width

  localparam logic [SELIN-1:0] FLUSH_CODE = {SELIN{1'b1}};

  // Stage count widened by one bit so the compare cannot overflow the code width.
  localparam logic [SELIN:0] N_STAGES = (SELIN+1)'(LOG2SLICES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [SELIN-1:0] first;
    logic [SELIN-1:0] last;
    logic [CNT_W-1:0] beats;
    logic             flush;
  } cmd_t;

  // A command is legal when both stage codes name an existing butterfly stage.
  function automatic logic cmd_legal(input logic [SELIN-1:0] first,
                                     input logic [SELIN-1:0] last);
    return ({1'b0, first} < N_STAGES) && ({1'b0, last} < N_STAGES);
  endfunction

endpackage

// File: rtl/iperm_sched_if.sv
// Command and kp token handshake bundle for the iperm scheduler.
// Latency: n/a (wires only).
// Backpressure: req/ack on both channels; transfer when both are high.
//
// master: command source and kp token sink (config path / iperm stage side).
// slave : the scheduler itself.
interface iperm_sched_if;
  import iperm_pkg::*;

  logic             t_cmd_req;
  logic             t_cmd_ack;
  logic [SELIN-1:0] t_cmd_first;
  logic [SELIN-1:0] t_cmd_last;
  logic [CNT_W-1:0] t_cmd_beats;
  logic             t_cmd_flush;

  logic             i_kp_req;
  logic             i_kp_ack;
  logic [SELIN-1:0] i_kp_code;

  modport master (
    output t_cmd_req, t_cmd_first, t_cmd_last, t_cmd_beats, t_cmd_flush,
    input  t_cmd_ack,
    input  i_kp_req, i_kp_code,
    output i_kp_ack
  );

  modport slave (
    input  t_cmd_req, t_cmd_first, t_cmd_last, t_cmd_beats, t_cmd_flush,
    output t_cmd_ack,
    output i_kp_req, i_kp_code,
    input  i_kp_ack
  );

endinterface

// File: rtl/iperm_beat_cnt.sv
// Loadable down-counter with zero flag, counting remaining beats in a stage.
// Latency: load/decrement visible the cycle after the request.
// Backpressure: none; decrement is ignored at zero (no wrap).
//
// Ports: clk, reset_n (sync, active-low), load/load_val, dec, cnt, zero.
module iperm_beat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/iperm_sched.sv
// Command-driven kp token sequencer: walks stage codes first..last, beats tokens each, optional flush token.
// Latency: command accepted in T -> first token in T+1; last transfer in L -> done/t_cmd_ack in L+1.
// Backpressure: kp tokens hold code until i_kp_ack; commands are only accepted in IDLE.
//
// Ports: clk, reset_n (sync, active-low), bus (iperm_sched_if.slave: command and kp channels),
//        busy (state != IDLE), done (completion pulse), err (sticky illegal-command flag).
module iperm_sched
  import iperm_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  iperm_sched_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t           state;
  cmd_t             cmd;
  logic [SELIN-1:0] last_r;
  logic [CNT_W-1:0] beats_m1_r;
  logic             flush_r;
  logic             step_dn_r;
  logic             kp_req_r;
  logic [SELIN-1:0] kp_code_r;

  logic             cmd_xfer;
  logic             kp_xfer;
  logic             legal;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             stage_step;

  assign cmd = '{first: bus.t_cmd_first, last: bus.t_cmd_last,
                 beats: bus.t_cmd_beats, flush: bus.t_cmd_flush};

  // Ack depends on state alone so the command source never sees a req->ack loop.
  assign bus.t_cmd_ack = (state == IDLE);
  assign bus.i_kp_req  = kp_req_r;
  assign bus.i_kp_code = kp_code_r;
  assign busy          = (state != IDLE);

  assign cmd_xfer = (state == IDLE) && bus.t_cmd_req;
  assign kp_xfer  = kp_req_r && bus.i_kp_ack;
  assign legal    = cmd_legal(cmd.first, cmd.last);

  // Stage advance happens on the transfer that exhausts the current stage's beats.
  assign stage_step = (state == RUN) && kp_xfer && cnt_zero && (kp_code_r != last_r);
  assign cnt_dec    = (state == RUN) && kp_xfer && !cnt_zero;

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = beats_m1_r;
    if (cmd_xfer && legal && (cmd.beats != '0)) begin
      cnt_load     = 1'b1;
      cnt_load_val = cmd.beats - CNT_W'(1);
    end else if (stage_step) begin
      cnt_load     = 1'b1;
    end
  end

  iperm_beat_cnt #(.W(CNT_W)) u_beat_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_r     <= '0;
      beats_m1_r <= '0;
      flush_r    <= 1'b0;
      step_dn_r  <= 1'b0;
      kp_req_r   <= 1'b0;
      kp_code_r  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.t_cmd_req) begin
            last_r     <= cmd.last;
            beats_m1_r <= cmd.beats - CNT_W'(1);
            flush_r    <= cmd.flush;
            step_dn_r  <= (cmd.first > cmd.last);
            err        <= 1'b0;
            if (!legal) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else if (cmd.beats == '0) begin
              if (cmd.flush) begin
                state     <= FLUSH;
                kp_req_r  <= 1'b1;
                kp_code_r <= FLUSH_CODE;
              end else begin
                done <= 1'b1;
              end
            end else begin
              state     <= RUN;
              kp_req_r  <= 1'b1;
              kp_code_r <= cmd.first;
            end
          end
        end

        RUN: begin
          // Mid-stage transfers only decrement the counter (handled in u_beat_cnt).
          if (kp_xfer && cnt_zero) begin
            if (kp_code_r != last_r) begin
              kp_code_r <= step_dn_r ? (kp_code_r - SELIN'(1)) : (kp_code_r + SELIN'(1));
            end else if (flush_r) begin
              state     <= FLUSH;
              kp_code_r <= FLUSH_CODE;
            end else begin
              state    <= IDLE;
              kp_req_r <= 1'b0;
              done     <= 1'b1;
            end
          end
        end

        FLUSH: begin
          if (kp_xfer) begin
            state    <= IDLE;
            kp_req_r <= 1'b0;
            done     <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          kp_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iperm_sched.sv
// Directed self-checking bench for iperm_sched.
// Latency: n/a.
// Backpressure: bench drives i_kp_ack patterns per scenario.
module tb_iperm_sched;
  import iperm_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy, done, err;

  iperm_sched_if bus ();

  iperm_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Observed status word: {t_cmd_ack, busy, done, err, i_kp_req, code-if-valid}.
  logic [7:0] obs;
  assign obs = {bus.t_cmd_ack, busy, done, err, bus.i_kp_req,
                (bus.i_kp_req ? bus.i_kp_code : 3'b000)};

  function automatic logic [7:0] ex(input logic a, input logic b, input logic d,
                                    input logic e, input logic r, input logic [2:0] c);
    return {a, b, d, e, r, (r ? c : 3'b000)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [2:0] l,
                      input logic [15:0] b, input logic fl);
    bus.t_cmd_req   = 1'b1;
    bus.t_cmd_first = f;
    bus.t_cmd_last  = l;
    bus.t_cmd_beats = b;
    bus.t_cmd_flush = fl;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset_n = 1'b0;
    tick();
    tick();
    e = ex(1, 0, 0, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_state: got %b expected %b", obs, e); end
    n_chk++;
    if (bus.i_kp_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", bus.i_kp_code); end
    reset_n = 1'b1;
    tick();
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, e); end
  endtask

  task automatic test_forward_sweep();
    logic [2:0] codes [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd7};
    logic [7:0] e;
    bus.i_kp_ack = 1'b1;
    send(3'd0, 3'd3, 16'd2, 1'b1);
    tick();
    bus.t_cmd_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = ex(0, 1, 0, 0, 1, codes[i]);
      n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL fwd_tok%0d: got %b expected %b", i, obs, e); end
      tick();
    end
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL fwd_done: got %b expected %b", obs, e); end
    tick();
    e = ex(1, 0, 0, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL fwd_idle: got %b expected %b", obs, e); end
  endtask

  task automatic test_reverse_backpressure();
    logic [2:0] codes [3] = '{3'd3, 3'd2, 3'd1};
    logic [7:0] e;
    bus.i_kp_ack = 1'b0;
    send(3'd3, 3'd1, 16'd1, 1'b0);
    tick();
    bus.t_cmd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = ex(0, 1, 0, 0, 1, codes[i]);
      n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL rev_tok%0d: got %b expected %b", i, obs, e); end
      tick();
      n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL rev_hold%0d: got %b expected %b", i, obs, e); end
      bus.i_kp_ack = 1'b1;
      tick();
      bus.i_kp_ack = 1'b0;
    end
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL rev_done: got %b expected %b", obs, e); end
  endtask

  task automatic test_edge_cmds();
    logic [7:0] e;
    bus.i_kp_ack = 1'b0;
    // beats=0 with flush: lone flush token.
    send(3'd1, 3'd2, 16'd0, 1'b1);
    tick();
    bus.t_cmd_req = 1'b0;
    e = ex(0, 1, 0, 0, 1, 3'd7);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL empty_flush_tok: got %b expected %b", obs, e); end
    bus.i_kp_ack = 1'b1;
    tick();
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL empty_flush_done: got %b expected %b", obs, e); end
    // beats=0 without flush: done next cycle, no tokens.
    send(3'd0, 3'd3, 16'd0, 1'b0);
    tick();
    bus.t_cmd_req = 1'b0;
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL empty_done: got %b expected %b", obs, e); end
    tick();
    e = ex(1, 0, 0, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL empty_quiet: got %b expected %b", obs, e); end
    // Illegal first stage.
    send(3'd5, 3'd1, 16'd3, 1'b1);
    tick();
    bus.t_cmd_req = 1'b0;
    e = ex(1, 0, 1, 1, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL illegal_done: got %b expected %b", obs, e); end
    tick();
    e = ex(1, 0, 0, 1, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL illegal_sticky: got %b expected %b", obs, e); end
    // Next legal command clears err.
    send(3'd2, 3'd2, 16'd1, 1'b0);
    tick();
    bus.t_cmd_req = 1'b0;
    e = ex(0, 1, 0, 0, 1, 3'd2);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL err_clear: got %b expected %b", obs, e); end
    tick();
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL err_clear_done: got %b expected %b", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] codes [3] = '{3'd2, 3'd2, 3'd7};
    logic [7:0] e;
    bus.i_kp_ack = 1'b1;
    send(3'd0, 3'd1, 16'd1, 1'b0);
    tick();
    send(3'd2, 3'd2, 16'd2, 1'b1);
    e = ex(0, 1, 0, 0, 1, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_a0: got %b expected %b", obs, e); end
    tick();
    e = ex(0, 1, 0, 0, 1, 3'd1);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_a1: got %b expected %b", obs, e); end
    tick();
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_a_done: got %b expected %b", obs, e); end
    tick();
    bus.t_cmd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = ex(0, 1, 0, 0, 1, codes[i]);
      n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b_b%0d: got %b expected %b", i, obs, e); end
      tick();
    end
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_b_done: got %b expected %b", obs, e); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] e;
    bus.i_kp_ack = 1'b1;
    send(3'd0, 3'd3, 16'd2, 1'b0);
    tick();
    bus.t_cmd_req = 1'b0;
    tick();
    tick();
    tick();
    e = ex(0, 1, 0, 0, 1, 3'd1);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_before_rst: got %b expected %b", obs, e); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    e = ex(1, 0, 0, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_rst_state: got %b expected %b", obs, e); end
    n_chk++;
    if (bus.i_kp_code !== 3'd0) begin n_fail++; $display("FAIL mid_rst_code: got %0d expected 0", bus.i_kp_code); end
    send(3'd1, 3'd2, 16'd1, 1'b0);
    tick();
    bus.t_cmd_req = 1'b0;
    e = ex(0, 1, 0, 0, 1, 3'd1);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_restart0: got %b expected %b", obs, e); end
    tick();
    e = ex(0, 1, 0, 0, 1, 3'd2);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_restart1: got %b expected %b", obs, e); end
    tick();
    e = ex(1, 0, 1, 0, 0, 3'd0);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL mid_restart_done: got %b expected %b", obs, e); end
  endtask

  initial begin
    bus.t_cmd_req   = 1'b0;
    bus.t_cmd_first = '0;
    bus.t_cmd_last  = '0;
    bus.t_cmd_beats = '0;
    bus.t_cmd_flush = 1'b0;
    bus.i_kp_ack    = 1'b0;
    test_reset();
    test_forward_sweep();
    test_reverse_backpressure();
    test_edge_cmds();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
